// File: rtl/uart_receiver_if.sv
// Receiver-side signal bundle: baud tick, serial line, FIFO back-pressure and the
// byte/status outputs that feed the RX FIFO and the status logic.
interface uart_receiver_if #(
  parameter int unsigned SIZE_DATA = 8
);
  logic                 i_stick;
  logic                 i_rx_serial;
  logic                 i_fifo_full;
  logic [SIZE_DATA-1:0] o_rx_data;
  logic                 o_rx_done;
  logic                 o_frame_err;
  logic                 o_overrun;
  logic                 o_rx_busy;

  modport slave (
    input  i_stick,
    input  i_rx_serial,
    input  i_fifo_full,
    output o_rx_data,
    output o_rx_done,
    output o_frame_err,
    output o_overrun,
    output o_rx_busy
  );

  modport master (
    output i_stick,
    output i_rx_serial,
    output i_fifo_full,
    input  o_rx_data,
    input  o_rx_done,
    input  o_frame_err,
    input  o_overrun,
    input  o_rx_busy
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled start-bit validation, mid-bit data sampling, stop-bit check,
// and one-cycle FIFO write / framing-error / overrun pulses.
module uart_receiver #(
  parameter int unsigned SIZE_DATA   = 8,
  parameter int unsigned OVER_SAMPLE = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  uart_receiver_if.slave  bus
);

  localparam int unsigned CW  = $clog2(OVER_SAMPLE);
  localparam int unsigned IW  = (SIZE_DATA > 1) ? $clog2(SIZE_DATA) : 1;
  localparam int unsigned MID = OVER_SAMPLE / 2;

  localparam logic [CW-1:0] CntMid  = CW'(MID - 1);
  localparam logic [CW-1:0] CntLast = CW'(OVER_SAMPLE - 1);
  localparam logic [IW-1:0] IdxLast = IW'(SIZE_DATA - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StStart   = 2'd1;
  localparam logic [1:0] StReceive = 2'd2;
  localparam logic [1:0] StStop    = 2'd3;

  logic                 r_sync1;
  logic                 r_rx_s;
  logic                 r_rx_d;
  logic [1:0]           r_state;
  logic [CW-1:0]        r_count;
  logic [IW-1:0]        r_index;
  logic [SIZE_DATA-1:0] r_shift;
  logic [SIZE_DATA-1:0] r_data;
  logic                 r_done;
  logic                 r_ferr;
  logic                 r_ovr;

  logic [1:0]           w_state_d;
  logic [CW-1:0]        w_count_d;
  logic [IW-1:0]        w_index_d;
  logic [SIZE_DATA-1:0] w_shift_d;
  logic [SIZE_DATA-1:0] w_data_d;
  logic                 w_done_d;
  logic                 w_ferr_d;
  logic                 w_ovr_d;
  logic                 w_start_edge;

  // Falling edge only: a line stuck LOW (break) cannot retrigger a frame.
  assign w_start_edge = r_rx_d & ~r_rx_s;

  always_comb begin
    w_state_d = r_state;
    w_count_d = r_count;
    w_index_d = r_index;
    w_shift_d = r_shift;
    w_data_d  = r_data;
    w_done_d  = 1'b0;
    w_ferr_d  = 1'b0;
    w_ovr_d   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_start_edge) begin
          w_state_d = StStart;
          w_count_d = '0;
          w_index_d = '0;
        end
      end
      StStart: begin
        if (bus.i_stick) begin
          if (r_count == CntMid) begin
            w_count_d = '0;
            w_state_d = r_rx_s ? StIdle : StReceive;
          end else begin
            w_count_d = r_count + 1'b1;
          end
        end
      end
      StReceive: begin
        if (bus.i_stick) begin
          if (r_count == CntLast) begin
            w_count_d          = '0;
            w_shift_d[r_index] = r_rx_s;
            if (r_index == IdxLast) begin
              w_index_d = '0;
              w_state_d = StStop;
            end else begin
              w_index_d = r_index + 1'b1;
            end
          end else begin
            w_count_d = r_count + 1'b1;
          end
        end
      end
      StStop: begin
        if (bus.i_stick) begin
          if (r_count == CntLast) begin
            w_count_d = '0;
            w_state_d = StIdle;
            if (!r_rx_s) begin
              w_ferr_d = 1'b1;
            end else if (bus.i_fifo_full) begin
              w_ovr_d = 1'b1;
            end else begin
              w_done_d = 1'b1;
              w_data_d = r_shift;
            end
          end else begin
            w_count_d = r_count + 1'b1;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_count_d = '0;
        w_index_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
      r_state <= StIdle;
      r_count <= '0;
      r_index <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sync1 <= bus.i_rx_serial;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
      r_state <= w_state_d;
      r_count <= w_count_d;
      r_index <= w_index_d;
      r_shift <= w_shift_d;
      r_data  <= w_data_d;
      r_done  <= w_done_d;
      r_ferr  <= w_ferr_d;
      r_ovr   <= w_ovr_d;
    end
  end

  assign bus.o_rx_data   = r_data;
  assign bus.o_rx_done   = r_done;
  assign bus.o_frame_err = r_ferr;
  assign bus.o_overrun   = r_ovr;
  assign bus.o_rx_busy   = (r_state != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames push expected flag/byte pairs,
// a negedge monitor pops and compares whenever a status pulse appears.
module tb_uart_receiver;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] div = 2'd0;

  always #5 clk = ~clk;
  always @(posedge clk) div <= div + 2'd1;

  uart_receiver_if #(.SIZE_DATA(8)) bus ();

  assign bus.i_stick = (div == 2'd3);

  uart_receiver #(
    .SIZE_DATA  (8),
    .OVER_SAMPLE(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  // kind: 0 = rx_done, 1 = frame_err, 2 = overrun
  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.o_rx_done || bus.o_frame_err || bus.o_overrun)) begin
      exp_t e;
      int   kind;
      chk("flags_exclusive",
          32'(int'(bus.o_rx_done) + int'(bus.o_frame_err) + int'(bus.o_overrun)), 32'd1);
      if (q.size() == 0) begin
        chk("unexpected_flag", {29'd0, bus.o_rx_done, bus.o_frame_err, bus.o_overrun}, 32'd0);
      end else begin
        e    = q.pop_front();
        kind = bus.o_rx_done ? 0 : (bus.o_frame_err ? 1 : 2);
        chk("flag_kind", 32'(kind), 32'(e.kind));
        chk("rx_data", {24'd0, bus.o_rx_data}, {24'd0, e.data});
      end
    end
  end

  task automatic ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (bus.i_stick) k++;
    end
    #1;
  endtask

  task automatic send_bit(input logic v, input int len);
    bus.i_rx_serial = v;
    ticks(len);
  endtask

  function automatic int jit(input int i);
    case (i % 3)
      0:       return 2;
      1:       return -2;
      default: return 0;
    endcase
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit jt);
    send_bit(1'b0, 16 + (jt ? jit(0) : 0));
    for (int i = 0; i < 8; i++) send_bit(b[i], 16 + (jt ? jit(i + 1) : 0));
    send_bit(stop, 16 + (jt ? jit(9) : 0));
  endtask

  initial begin
    rst             = 1'b1;
    bus.i_rx_serial = 1'b1;
    bus.i_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", {24'd0, bus.o_rx_data}, 32'd0);
    chk("reset_done", {31'd0, bus.o_rx_done}, 32'd0);
    chk("reset_ferr", {31'd0, bus.o_frame_err}, 32'd0);
    chk("reset_ovr", {31'd0, bus.o_overrun}, 32'd0);
    chk("reset_busy", {31'd0, bus.o_rx_busy}, 32'd0);
    rst = 1'b0;
    ticks(4);

    // Clean frame
    q.push_back('{0, 8'hA5});
    send_frame(8'hA5, 1'b1, 1'b0);
    ticks(8);

    // Start glitch: LOW for 5 ticks only
    bus.i_rx_serial = 1'b0;
    ticks(3);
    chk("glitch_busy_during", {31'd0, bus.o_rx_busy}, 32'd1);
    ticks(2);
    bus.i_rx_serial = 1'b1;
    ticks(5);
    chk("glitch_busy_after", {31'd0, bus.o_rx_busy}, 32'd0);
    ticks(4);

    // Framing error followed by a break, then line recovers
    q.push_back('{1, 8'hA5});
    send_frame(8'h3C, 1'b0, 1'b0);
    ticks(8);
    chk("break_no_restart", {31'd0, bus.o_rx_busy}, 32'd0);
    bus.i_rx_serial = 1'b1;
    ticks(8);
    chk("ferr_data_held", {24'd0, bus.o_rx_data}, 32'h0000_00A5);

    // Overrun: FIFO full
    bus.i_fifo_full = 1'b1;
    q.push_back('{2, 8'hA5});
    send_frame(8'h81, 1'b1, 1'b0);
    ticks(4);
    bus.i_fifo_full = 1'b0;
    chk("ovr_data_held", {24'd0, bus.o_rx_data}, 32'h0000_00A5);

    // Reset during data bit 3 of 0x5A
    send_bit(1'b0, 16);
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 16);
    send_bit(1'b1, 8);
    chk("midframe_busy", {31'd0, bus.o_rx_busy}, 32'd1);
    bus.i_rx_serial = 1'b1;
    rst             = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", {31'd0, bus.o_rx_busy}, 32'd0);
    chk("midrst_data", {24'd0, bus.o_rx_data}, 32'd0);
    rst = 1'b0;
    ticks(20);
    q.push_back('{0, 8'h5A});
    send_frame(8'h5A, 1'b1, 1'b0);
    ticks(4);

    // Back-to-back with per-bit jitter
    q.push_back('{0, 8'h00});
    q.push_back('{0, 8'hFF});
    q.push_back('{0, 8'h55});
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 1'b1);
    ticks(8);

    for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_data", {24'd0, bus.o_rx_data}, 32'h0000_0055);
    chk("final_busy", {31'd0, bus.o_rx_busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
